// File: rtl/demux32_buf.sv
// Registered 1-to-2 demux: one input word steered by s into
// one of two small FIFOs, each drained by its own valid/ready port.
module demux32_buf #(
  parameter int W     = 32,
  parameter int DEPTH = 2,
  parameter int CW    = 8
) (
  input  logic          c,
  input  logic          rst,
  input  logic [W-1:0]  i,
  input  logic          s,
  input  logic          iv,
  output logic          ir,
  output logic [W-1:0]  o0,
  output logic          v0,
  input  logic          r0,
  output logic [W-1:0]  o1,
  output logic          v1,
  input  logic          r1,
  output logic [CW-1:0] n0,
  output logic [CW-1:0] n1
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem0 [DEPTH];
  logic [W-1:0]  mem1 [DEPTH];
  logic [AW-1:0] wp0, rp0, wp1, rp1;
  logic [AW:0]   cnt0, cnt1;
  logic          full0, full1;
  logic          push0, push1, pop0, pop1;

  assign full0 = (cnt0 == FULL);
  assign full1 = (cnt1 == FULL);

  // Head-of-line: readiness follows only the selected FIFO.
  assign ir = ~rst & ~(s ? full1 : full0);

  assign push0 = iv & ir & ~s;
  assign push1 = iv & ir & s;
  assign pop0  = v0 & r0;
  assign pop1  = v1 & r1;

  assign v0 = (cnt0 != '0);
  assign v1 = (cnt1 != '0);
  assign o0 = v0 ? mem0[rp0] : '0;
  assign o1 = v1 ? mem1[rp1] : '0;

  always_ff @(posedge c) begin
    if (push0) mem0[wp0] <= i;
    if (push1) mem1[wp1] <= i;
  end

  always_ff @(posedge c) begin
    if (rst) begin
      wp0  <= '0;
      rp0  <= '0;
      cnt0 <= '0;
      n0   <= '0;
    end else begin
      if (push0) begin
        wp0 <= wp0 + 1'b1;
        n0  <= n0 + 1'b1;
      end
      if (pop0) rp0 <= rp0 + 1'b1;
      unique case (1'b1)
        push0 & ~pop0: cnt0 <= cnt0 + 1'b1;
        pop0 & ~push0: cnt0 <= cnt0 - 1'b1;
        default:       cnt0 <= cnt0;
      endcase
    end
  end

  always_ff @(posedge c) begin
    if (rst) begin
      wp1  <= '0;
      rp1  <= '0;
      cnt1 <= '0;
      n1   <= '0;
    end else begin
      if (push1) begin
        wp1 <= wp1 + 1'b1;
        n1  <= n1 + 1'b1;
      end
      if (pop1) rp1 <= rp1 + 1'b1;
      unique case (1'b1)
        push1 & ~pop1: cnt1 <= cnt1 + 1'b1;
        pop1 & ~push1: cnt1 <= cnt1 - 1'b1;
        default:       cnt1 <= cnt1;
      endcase
    end
  end

endmodule

// File: doc/demux32_buf.md
# demux32_buf

Registered 1-to-2 demultiplexer: the distribution counterpart of the datapath's 2-to-1 registered mux. One 32-bit input word, steered by a select bit, is buffered into one of two small output FIFOs, each drained by its own valid/ready consumer. It sits between a single ALU or result producer and two downstream consumers, such as the register writeback and store paths. Per-output transfer counters support debug and verification.

## Interface
- W, 32, data width.
- DEPTH, 2, entries per output FIFO; power of two, at least 2.
- CW, 8, width of each transfer counter.

- c  in  1  clock; all state updates on posedge c.
- rst  in  1  synchronous, active-high reset.
- i  in  W  input data word.
- s  in  1  select: 0 steers to output 0, 1 steers to output 1.
- iv  in  1  input valid.
- ir  out  1  input ready.
- o0  out  W  output 0 data (head of FIFO 0).
- v0  out  1  output 0 valid.
- r0  in  1  output 0 ready.
- o1  out  W  output 1 data (head of FIFO 1).
- v1  out  1  output 1 valid.
- r1  in  1  output 1 ready.
- n0  out  CW  count of words accepted for output 0.
- n1  out  CW  count of words accepted for output 1.

## Operation
- Two independent circular FIFOs, each DEPTH entries deep. Each has a write pointer, a read pointer and an occupancy count of width log2(DEPTH)+1.
- ir = ~rst & ~full[s]. ir is combinational from s and the registered full flags only; it has no dependence on iv.
- Push: when iv & ir at a posedge, i is written to FIFO[s]. That FIFO's write pointer increments modulo DEPTH, its occupancy increments, and n[s] increments.
- Pop: when vk & rk at a posedge, FIFO k's read pointer increments modulo DEPTH and its occupancy decrements.
- vk = (occupancy k != 0). ok = head entry when vk=1, else all zeros.
- Simultaneous push and pop on the same FIFO:
  - If not full, both take effect and occupancy is unchanged.
  - If full, ir=0, so only the pop occurs. There is no same-cycle pass-through into a freed slot.
- Push to one FIFO and pop from the other in the same cycle are fully independent.
- s is sampled only when iv & ir. When iv=0, s is don't-care and nothing is written.
- Counters n0 and n1 wrap from 2^CW−1 to 0 without saturating or flagging. Pops do not affect the counters.
- Reset (rst=1 at a posedge), including mid-operation:
  - Both FIFOs are emptied: pointers and occupancy go to 0.
  - n0 = n1 = 0.
  - A push or pop presented in the same cycle is discarded.
  - FIFO memory contents are not cleared; they are unobservable because ok is gated by vk.
- Reset values of outputs: ir=0 while rst is high, and 1 in the first cycle after rst falls. v0=v1=0, o0=o1=0, n0=n1=0.

## Timing
- Latency: a word accepted at posedge k is visible on ok/vk after posedge k, so it can be popped at posedge k+1. Minimum latency is 1 cycle.
- Throughput: one push per cycle in total, plus one pop per output per cycle. Sustained full rate into one output requires that output's rk=1 every cycle.
- FIFO full: occupancy = DEPTH. ir drops in the cycle after the filling push, and only while s selects that FIFO.
- Head-of-line: if s selects a full FIFO, the word waits (ir=0) even when the other FIFO has room. The producer holds i, s and iv until ir=1.
- All outputs except ir are driven from registers or registered-state-gated memory, with no combinational path from iv, r0 or r1. ir depends combinationally on s.

## Test plan
- Reset, then idle: ir=1, v0=v1=0, o0=o1=0, n0=n1=0.
- Single steer: push i=0xDEADBEEF, s=1. After the next edge: v1=1, o1=0xDEADBEEF, v0=0, n1=1. Pop with r1=1: v1=0, o1=0.
- Fill and order, DEPTH=2, r0=0: push 0x11, then 0x22, with s=0. Then ir=0 while s=0 and ir=1 while s=1. Raise r0: pops return 0x11 then 0x22, in order.
- Full with simultaneous pop: FIFO 0 full, iv=1, s=0, r0=1 in the same cycle. Exactly one pop occurs, no push, occupancy becomes DEPTH−1. The word is accepted on the next cycle.
- Interleave and wrap: 300 pushes alternating s, with random r0/r1 held high 50% of cycles. Every word emerges on the correct output in order, and n0 = n1 = 150 mod 256 = 150 (pointer wrap exercised).
- Reset mid-operation: both FIFOs partially full, assert rst for 1 cycle with iv=1 and r0=r1=1. Next cycle: v0=v1=0, n0=n1=0, and no stale data appears afterward.
